// File: rtl/pwm_duty_calc.sv
// PWM duty calculator: captures high/low counts, forms the period and
// computes duty = floor(high*SCALE/period) with a serial restoring divider.
module pwm_duty_calc #(
    parameter int CNT_W   = 32,
    parameter int SCALE   = 1000,
    parameter int SCALE_W = 10
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [CNT_W-1:0]   count_high,
    input  logic [CNT_W-1:0]   count_low,
    input  logic               hready_intr,
    input  logic               lready_intr,
    output logic [CNT_W-1:0]   high_out,
    output logic [CNT_W-1:0]   low_out,
    output logic [CNT_W:0]     period_out,
    output logic [SCALE_W-1:0] duty_out,
    output logic               result_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int NUM_W = CNT_W + SCALE_W;
    localparam int CW    = $clog2(NUM_W);
    localparam logic [CW-1:0]    LAST    = CW'(NUM_W - 1);
    localparam logic [NUM_W-1:0] SCALE_N = NUM_W'(SCALE);

    typedef enum logic [1:0] {
        S_WAIT_HIGH,
        S_WAIT_LOW,
        S_DIV
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0] high_q;
    logic [CNT_W-1:0] low_q;
    logic [CNT_W-1:0] hi_d;
    logic [CNT_W-1:0] pend_high;
    logic             pend_flag;
    logic [NUM_W-1:0] num_q;
    logic [CNT_W:0]   div_q;
    logic [CNT_W:0]   rem_q;
    logic [CW-1:0]    cnt;
    logic             done_q;

    logic [NUM_W-1:0] num_load;
    logic [CNT_W+1:0] shifted;
    logic [CNT_W:0]   diff;
    logic             fits;
    logic             zero_div;
    logic             last_step;
    logic             finish;

    assign num_load  = {{SCALE_W{1'b0}}, high_q} * SCALE_N;
    assign shifted   = {rem_q, num_q[NUM_W-1]};
    assign fits      = shifted >= {1'b0, div_q};
    // Only used when fits, so the true difference is below div_q.
    assign diff      = shifted[CNT_W:0] - div_q;
    assign zero_div  = (state == S_DIV) && (div_q == '0);
    assign last_step = (state == S_DIV) && (div_q != '0) && (cnt == LAST);
    assign finish    = zero_div || last_step;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_WAIT_HIGH;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_WAIT_HIGH: begin
                if (hready_intr) state_next = S_WAIT_LOW;
            end
            S_WAIT_LOW: begin
                if (lready_intr) state_next = S_DIV;
            end
            S_DIV: begin
                if (finish) begin
                    if (pend_flag || hready_intr) state_next = S_WAIT_LOW;
                    else                          state_next = S_WAIT_HIGH;
                end
            end
            default: state_next = S_WAIT_HIGH;
        endcase
    end

    always_comb begin
        busy = (state == S_DIV);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            high_q       <= '0;
            low_q        <= '0;
            hi_d         <= '0;
            pend_high    <= '0;
            pend_flag    <= 1'b0;
            num_q        <= '0;
            div_q        <= '0;
            rem_q        <= '0;
            cnt          <= '0;
            done_q       <= 1'b0;
            overrun      <= 1'b0;
            high_out     <= '0;
            low_out      <= '0;
            period_out   <= '0;
            duty_out     <= '0;
            result_valid <= 1'b0;
        end else begin
            done_q       <= last_step;
            result_valid <= done_q || zero_div;

            // Outputs are published one edge after the final divider step.
            if (done_q) begin
                high_out   <= hi_d;
                low_out    <= low_q;
                period_out <= div_q;
                duty_out   <= num_q[SCALE_W-1:0];
            end else if (zero_div) begin
                high_out   <= hi_d;
                low_out    <= low_q;
                period_out <= '0;
                duty_out   <= '0;
            end

            case (state)
                S_WAIT_HIGH: begin
                    if (hready_intr) high_q <= count_high;
                end
                S_WAIT_LOW: begin
                    if (lready_intr) begin
                        low_q <= count_low;
                        hi_d  <= high_q;
                        num_q <= num_load;
                        div_q <= {1'b0, high_q} + {1'b0, count_low};
                        rem_q <= '0;
                        cnt   <= '0;
                        if (hready_intr) begin
                            pend_high <= count_high;
                            pend_flag <= 1'b1;
                        end
                    end else if (hready_intr) begin
                        high_q <= count_high;
                    end
                end
                S_DIV: begin
                    if (hready_intr) begin
                        pend_high <= count_high;
                        pend_flag <= 1'b1;
                    end
                    if (lready_intr) overrun <= 1'b1;
                    if (!zero_div) begin
                        rem_q <= fits ? diff : shifted[CNT_W:0];
                        num_q <= {num_q[NUM_W-2:0], fits};
                        cnt   <= cnt + CW'(1);
                    end
                    if (finish) begin
                        pend_flag <= 1'b0;
                        if (hready_intr)    high_q <= count_high;
                        else if (pend_flag) high_q <= pend_high;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_duty_calc.sv
// Scoreboard bench for pwm_duty_calc: directed measurements push expected
// results; a monitor pops and compares on every result_valid.
module tb_pwm_duty_calc;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] count_high;
    logic [31:0] count_low;
    logic        hready_intr;
    logic        lready_intr;
    logic [31:0] high_out;
    logic [31:0] low_out;
    logic [32:0] period_out;
    logic [9:0]  duty_out;
    logic        result_valid;
    logic        busy;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] h;
        logic [31:0] l;
        logic [32:0] p;
        logic [9:0]  d;
    } exp_t;

    exp_t q[$];

    pwm_duty_calc #(.CNT_W(32), .SCALE(1000), .SCALE_W(10)) dut (
        .clk(clk),
        .reset(reset),
        .count_high(count_high),
        .count_low(count_low),
        .hready_intr(hready_intr),
        .lready_intr(lready_intr),
        .high_out(high_out),
        .low_out(low_out),
        .period_out(period_out),
        .duty_out(duty_out),
        .result_valid(result_valid),
        .busy(busy),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (result_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result: got duty %0d expected none",
                         duty_out);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("high_out", 64'(high_out), 64'(e.h));
                chk("low_out", 64'(low_out), 64'(e.l));
                chk("period_out", 64'(period_out), 64'(e.p));
                chk("duty_out", 64'(duty_out), 64'(e.d));
            end
        end
    end

    task automatic pulse_h(input logic [31:0] v);
        @(negedge clk);
        count_high  = v;
        hready_intr = 1'b1;
        @(negedge clk);
        hready_intr = 1'b0;
    endtask

    task automatic pulse_l(input logic [31:0] v);
        @(negedge clk);
        count_low   = v;
        lready_intr = 1'b1;
        @(negedge clk);
        lready_intr = 1'b0;
    endtask

    task automatic expect_res(input logic [31:0] h, input logic [31:0] l,
                              input logic [32:0] p, input logic [9:0] d);
        exp_t e;
        e.h = h;
        e.l = l;
        e.p = p;
        e.d = d;
        q.push_back(e);
    endtask

    task automatic meas(input logic [31:0] h, input logic [31:0] l,
                        input logic [32:0] p, input logic [9:0] d);
        pulse_h(h);
        expect_res(h, l, p, d);
        pulse_l(l);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: got %0d pending expected 0", name,
                     q.size());
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        int lat;
        int busy_n;
        reset       = 1'b1;
        count_high  = '0;
        count_low   = '0;
        hready_intr = 1'b0;
        lready_intr = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_duty", 64'(duty_out), 64'd0);
        chk("reset_period", 64'(period_out), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_overrun", 64'(overrun), 64'd0);

        // Test 1: latency and busy length
        pulse_h(32'd250);
        expect_res(32'd250, 32'd750, 33'd1000, 10'd250);
        @(negedge clk);
        count_low   = 32'd750;
        lready_intr = 1'b1;
        @(posedge clk);
        #1;
        lready_intr = 1'b0;
        lat    = 0;
        busy_n = busy ? 1 : 0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            if (busy) busy_n++;
            if (result_valid) begin
                lat = i;
                break;
            end
        end
        chk("latency", 64'(lat), 64'd43);
        chk("busy_cycles", 64'(busy_n), 64'd42);
        wait_done("t1");

        // Test 2
        meas(32'd1, 32'd2, 33'd3, 10'd333);
        wait_done("t2a");
        meas(32'd0, 32'd500, 33'd500, 10'd0);
        wait_done("t2b");
        meas(32'd500, 32'd0, 33'd500, 10'd1000);
        wait_done("t2c");

        // Test 3
        meas(32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFE, 10'd500);
        wait_done("t3a");
        meas(32'hFFFF_FFFF, 32'd0, 33'h0_FFFF_FFFF, 10'd1000);
        wait_done("t3b");

        // Test 4: stray lready is ignored
        pulse_l(32'd123);
        repeat (60) @(negedge clk);
        chk("stray_l_busy", 64'(busy), 64'd0);
        meas(32'd3, 32'd1, 33'd4, 10'd750);
        wait_done("t4");

        // Test 5: pending high and overrun
        meas(32'd100, 32'd100, 33'd200, 10'd500);
        repeat (5) @(negedge clk);
        pulse_h(32'd40);
        wait_done("t5a");
        expect_res(32'd40, 32'd60, 33'd100, 10'd400);
        pulse_l(32'd60);
        wait_done("t5b");
        chk("overrun_clear", 64'(overrun), 64'd0);
        meas(32'd10, 32'd10, 33'd20, 10'd500);
        repeat (5) @(negedge clk);
        pulse_l(32'd99);
        wait_done("t5c");
        chk("overrun_set", 64'(overrun), 64'd1);
        repeat (20) @(negedge clk);
        chk("overrun_sticky", 64'(overrun), 64'd1);

        // Test 6: reset mid-division
        do_reset();
        pulse_h(32'd300);
        pulse_l(32'd700);
        repeat (9) @(negedge clk);
        chk("mid_div_busy", 64'(busy), 64'd1);
        do_reset();
        chk("rst_high", 64'(high_out), 64'd0);
        chk("rst_low", 64'(low_out), 64'd0);
        chk("rst_period", 64'(period_out), 64'd0);
        chk("rst_duty", 64'(duty_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        repeat (60) @(negedge clk);
        meas(32'd300, 32'd700, 33'd1000, 10'd300);
        wait_done("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pwm_duty_calc.md
Name: pwm_duty_calc

Overview:
- Sits directly downstream of the PWM high/low time detector.
- Captures each high-count and low-count measurement on its single-cycle ready pulses and forms period = high + low.
- Computes duty = floor(high * SCALE / period) with a multi-cycle restoring divider.
- Presents latched high, low, period and duty values with a one-cycle result_valid strobe, for the AXI register/interrupt wrapper to read.

Parameters:
- CNT_W, 32, width of incoming high/low counts
- SCALE, 1000, full-scale duty value (1000 = per-mille)
- SCALE_W, 10, width of duty output; must satisfy 2^SCALE_W > SCALE

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- count_high  in  CNT_W  high-phase count; valid in the cycle hready_intr=1
- count_low  in  CNT_W  low-phase count; valid in the cycle lready_intr=1
- hready_intr  in  1  single-cycle pulse, high count ready
- lready_intr  in  1  single-cycle pulse, low count ready
- high_out  out  CNT_W  high count of the last completed period
- low_out  out  CNT_W  low count of the last completed period
- period_out  out  CNT_W+1  high_out + low_out, full width with no overflow
- duty_out  out  SCALE_W  floor(high_out*SCALE/period_out); range 0..SCALE
- result_valid  out  1  one-cycle pulse when all *_out registers update
- busy  out  1  high while the divider runs
- overrun  out  1  sticky flag; cleared only by reset

Behaviour:
- Reset: clk is the clock; reset is synchronous, active-high. All outputs go to 0, all internal captures and flags clear, and state becomes S_WAIT_HIGH. A reset during S_DIV aborts the division; no result_valid is produced.
- Internal widths: NUM_W = CNT_W + SCALE_W (42 at defaults). Numerator = high_q * SCALE (NUM_W bits). Divisor = high_q + low_q (CNT_W+1 bits).
- S_WAIT_HIGH:
  - hready_intr=1: high_q <= count_high, go to S_WAIT_LOW.
  - lready_intr alone is ignored (measurement started mid-low).
- S_WAIT_LOW:
  - hready_intr alone: recapture high_q, stay.
  - lready_intr=1: low_q <= count_low; load the divider with numerator, divisor, remainder 0 and iteration counter 0; go to S_DIV.
  - hready_intr and lready_intr together: the lready path wins and uses the old high_q. The new count_high is stored in pend_high and pend_flag is set.
- S_DIV:
  - busy=1. One restoring-division step per cycle, MSB first, for exactly NUM_W cycles.
  - After the last step, register high_out, low_out, period_out and duty_out (low SCALE_W bits of the quotient). Pulse result_valid for one cycle.
  - Next state: S_WAIT_LOW with high_q <= pend_high if pend_flag, else S_WAIT_HIGH. Clear pend_flag.
- Latency: result_valid is high in the cycle following the (NUM_W+1)-th rising edge after the edge that samples lready_intr. At defaults that is 43 edges. The divider operand registers are independent of high_q and low_q, so captures during S_DIV do not corrupt the division.
- hready_intr during S_DIV: pend_high <= count_high, pend_flag <= 1. A second hready overwrites pend_high.
- lready_intr during S_DIV: the sample is dropped and overrun is set (sticky).
- period == 0: skip division. At the next edge, outputs update with duty_out=0 and result_valid pulses (latency 1). Return as for a normal completion.
- high == 0 gives duty_out=0. low == 0 with high > 0 gives duty_out=SCALE.
- Rounding is truncation (floor). Quotient bits above SCALE_W are always 0, because high ≤ period.
- Outputs hold their values between result_valid pulses.

Test Plan:
1. Reset, then hready with count_high=250, then lready with count_low=750 → result_valid exactly 43 edges after the lready edge; high_out=250, low_out=750, period_out=1000, duty_out=250; busy high for 42 cycles.
2. high=1, low=2 → duty_out=333, period_out=3. high=0, low=500 → duty_out=0. high=500, low=0 → duty_out=1000.
3. high=low=32'hFFFFFFFF → period_out=33'h1_FFFFFFFE, duty_out=500. high=32'hFFFFFFFF, low=0 → duty_out=1000.
4. lready before any hready after reset → no result_valid, state stays S_WAIT_HIGH. Then a hready/lready sequence produces a normal result.
5. During S_DIV: hready with high=40 → after completion, a following lready with low=60 yields duty_out=400 without a new hready. A separate lready during S_DIV → overrun=1 and stays 1 until reset.
6. Assert reset 10 cycles into S_DIV → no result_valid; all outputs read 0. Next full hready/lready pair → correct result.
